// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads on the instruction bus,
// buffers returned words in a prefetch FIFO and hands them to decode one per handshake.
module inst_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;
  logic          started_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [FIFO_DEPTH];
  logic [31:0]   addr_mem_q [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   jump_tgt;
  logic          req, issue, rsp, push, pop;
  logic          unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign jump_tgt        = {jump_addr_i[31:2], 2'b00};

  // Credit rule: buffered words plus in-flight requests never exceed the FIFO size.
  always_comb begin
    credit_used = {1'b0, cnt_q} + {1'b0, out_q};
    req   = started_q & ~hold_i & ~jump_flag_i & (credit_used < (CW+1)'(FIFO_DEPTH));
    issue = req & bus_gnt_i;
    rsp   = bus_rvalid_i & (out_q != '0);
    push  = rsp & (disc_q == '0) & ~jump_flag_i;
    pop   = (cnt_q != '0) & inst_ready_i & ~jump_flag_i;
  end

  always_comb begin
    pc_d       = issue ? pc_q + 32'd4 : pc_q;
    out_d      = out_q + CW'(issue) - CW'(rsp);
    rsp_addr_d = push ? rsp_addr_q + 32'd4 : rsp_addr_q;
    disc_d     = (rsp && disc_q != '0) ? disc_q - CW'(1) : disc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    if (jump_flag_i) begin
      // Every response still in flight after this edge belongs to the stale stream.
      pc_d       = jump_tgt;
      rsp_addr_d = jump_tgt;
      disc_d     = out_q - CW'(rsp);
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= BOOT_ADDR;
      rsp_addr_q <= BOOT_ADDR;
      started_q  <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_addr_q <= rsp_addr_d;
      started_q  <= 1'b1;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= bus_rdata_i;
      addr_mem_q[wr_ptr_q] <= rsp_addr_q;
    end
  end

  assign bus_req_o    = req;
  assign bus_addr_o   = pc_q;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? addr_mem_q[rd_ptr_q] : 32'h0;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (cnt_q < CW'(FIFO_DEPTH)) || pop);
  a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_rvalid_i |-> (out_q != '0));
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order bus model plus a scoreboard of granted addresses
// that is flushed on redirect and popped on every decode handshake.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_i = 1'b0;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_gnt_i = 1'b1;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] rsp_q[$];
  logic [31:0] exp_pc = BOOT;
  bit          rsp_hold = 1'b0;
  bit          rnd_mode = 1'b0;
  bit          ok;
  bit          seen;
  bit          req_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit          vld_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  inst_fetch_unit #(.FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT), .NOP_INST(NOP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_i(hold_i), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5EED_0001;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic wait_out(input bit want_valid, input int n, output bit found);
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      at_neg();
      if ((want_valid ? inst_valid_o : bus_req_o) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    step();
    hold_i = 1'b1;
    inst_ready_i = 1'b1;
    jump_flag_i = 1'b0;
    repeat (8) step();
  endtask

  // Bus model: in-order responses at least one cycle after the grant.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk_i);
      #2;
      if (!rst_ni) begin
        rsp_q.delete();
        bus_rvalid_i = 1'b0;
      end else if (!rsp_hold && rsp_q.size() > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        a = rsp_q.pop_front();
        bus_rvalid_i = 1'b1;
        bus_rdata_i = memf(a);
      end else begin
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'hDEAD_BEEF;
      end
      bus_gnt_i = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [31:0] ea;
    forever begin
      at_neg();
      if (!rst_ni) begin
        sb.delete();
        exp_pc = BOOT;
      end else begin
        if (hold_i || jump_flag_i) chk("req_blocked", {31'b0, bus_req_o}, 32'h0);
        if (bus_req_o && bus_gnt_i) begin
          chk("req_addr", bus_addr_o, exp_pc);
          rsp_q.push_back(bus_addr_o);
          sb.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
        if (jump_flag_i) begin
          sb.delete();
          exp_pc = {jump_addr_i[31:2], 2'b00};
        end else if (inst_valid_o && inst_ready_i) begin
          chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'h1);
          if (sb.size() != 0) begin
            ea = sb.pop_front();
            chk("out_addr", inst_addr_o, ea);
            chk("out_data", inst_o, memf(ea));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then the first fetches after release
    step();
    at_neg();
    chk("rst_req", {31'b0, bus_req_o}, 32'h0);
    chk("rst_addr", bus_addr_o, BOOT);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_iaddr", inst_addr_o, 32'h0);
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      at_neg();
      chk($sformatf("s1_req%0d", k), {31'b0, bus_req_o}, {31'b0, req_tab[k]});
      chk($sformatf("s1_vld%0d", k), {31'b0, inst_valid_o}, {31'b0, vld_tab[k]});
      if (k == 3) chk("s1_first_addr", inst_addr_o, 32'h0);
      if (k == 4) chk("s1_req_addr8", bus_addr_o, 32'h8);
    end
    repeat (6) step();

    // Back-pressure with a full FIFO
    rst_ni = 1'b0;
    inst_ready_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("s2_stall_req", {31'b0, bus_req_o}, 32'h0);
      step();
    end
    at_neg();
    chk("s2_full_valid", {31'b0, inst_valid_o}, 32'h1);
    chk("s2_head", inst_addr_o, 32'h0);
    step();
    inst_ready_i = 1'b1;
    at_neg();
    chk("s2_req_still_low", {31'b0, bus_req_o}, 32'h0);
    step();
    at_neg();
    chk("s2_resume_req", {31'b0, bus_req_o}, 32'h1);
    chk("s2_resume_addr", bus_addr_o, 32'h8);
    chk("s2_next_head", inst_addr_o, 32'h4);
    repeat (6) step();

    // Redirect with two requests in flight
    drain();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h10;
    rsp_hold = 1'b1;
    step();
    jump_flag_i = 1'b0;
    hold_i = 1'b0;
    at_neg();
    chk("s3_req10", bus_addr_o, 32'h10);
    step();
    at_neg();
    chk("s3_req14", bus_addr_o, 32'h14);
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    at_neg();
    chk("s3_jump_req", {31'b0, bus_req_o}, 32'h0);
    step();
    jump_flag_i = 1'b0;
    rsp_hold = 1'b0;
    wait_out(1'b0, 20, ok);
    chk("s3_req_seen", {31'b0, ok}, 32'h1);
    chk("s3_new_addr", bus_addr_o, 32'h100);
    wait_out(1'b1, 20, ok);
    chk("s3_valid_seen", {31'b0, ok}, 32'h1);
    chk("s3_first_addr", inst_addr_o, 32'h100);
    chk("s3_first_data", inst_o, memf(32'h100));

    // Redirect coinciding with a response while the FIFO holds a word
    drain();
    inst_ready_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h1C;
    step();
    jump_flag_i = 1'b0;
    hold_i = 1'b0;
    step();
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    at_neg();
    chk("s4_pre_valid", {31'b0, inst_valid_o}, 32'h1);
    chk("s4_pre_head", inst_addr_o, 32'h1C);
    step();
    jump_flag_i = 1'b0;
    inst_ready_i = 1'b1;
    at_neg();
    chk("s4_flushed", {31'b0, inst_valid_o}, 32'h0);
    wait_out(1'b1, 20, ok);
    chk("s4_valid_seen", {31'b0, ok}, 32'h1);
    chk("s4_first_addr", inst_addr_o, 32'h200);

    // Hold with one request outstanding
    drain();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h40;
    rsp_hold = 1'b1;
    step();
    jump_flag_i = 1'b0;
    hold_i = 1'b0;
    at_neg();
    chk("s5_req40", bus_addr_o, 32'h40);
    step();
    hold_i = 1'b1;
    rsp_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("s5_hold_req", {31'b0, bus_req_o}, 32'h0);
      if (inst_valid_o && inst_addr_o == 32'h40) seen = 1'b1;
      if (i < 4) step();
    end
    chk("s5_delivered", {31'b0, seen}, 32'h1);
    step();
    hold_i = 1'b0;
    at_neg();
    chk("s5_resume_req", {31'b0, bus_req_o}, 32'h1);
    chk("s5_resume_addr", bus_addr_o, 32'h44);
    repeat (4) step();

    // PC wrap at the top of the address space
    drain();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    step();
    jump_flag_i = 1'b0;
    hold_i = 1'b0;
    at_neg();
    chk("s6_req_top", bus_addr_o, 32'hFFFF_FFFC);
    step();
    at_neg();
    chk("s6_req_wrap_v", {31'b0, bus_req_o}, 32'h1);
    chk("s6_req_wrap", bus_addr_o, 32'h0);
    repeat (8) step();

    // Random traffic: grants, response gaps, back-pressure, holds and redirects
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      inst_ready_i = ($urandom_range(0, 3) != 0);
      hold_i = ($urandom_range(0, 7) == 0);
      jump_flag_i = ($urandom_range(0, 15) == 0);
      jump_addr_i = $urandom;
    end
    rnd_mode = 1'b0;
    drain();

    // Reset in the middle of a stream
    hold_i = 1'b0;
    inst_ready_i = 1'b0;
    repeat (6) step();
    at_neg();
    chk("s7_pre_valid", {31'b0, inst_valid_o}, 32'h1);
    step();
    rst_ni = 1'b0;
    #1;
    chk("s7_rst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("s7_rst_req", {31'b0, bus_req_o}, 32'h0);
    chk("s7_rst_inst", inst_o, NOP);
    step();
    step();
    rst_ni = 1'b1;
    inst_ready_i = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the pipeline. Owns the PC and issues word reads on the instruction bus.
- Buffers returned words in a small prefetch FIFO and presents one instruction plus its address per handshake to the if_id/decode stage.
- Redirects on the execute-stage jump flag and discards in-flight responses from the stale stream.

Parameters:
- FIFO_DEPTH, 2: prefetch entries; also the maximum of outstanding requests plus buffered words. Legal values are 2 or 4.
- BOOT_ADDR, 32'h0000_0000: PC value after reset.
- NOP_INST, 32'h0000_0013: instruction driven on inst_o while inst_valid_o=0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous assertion, active-low
- jump_flag_i  in  1  redirect request from ex
- jump_addr_i  in  32  redirect target
- hold_i  in  1  pipeline hold; while high, no new bus requests are issued
- bus_req_o  out  1  read request
- bus_addr_o  out  32  word address, bits[1:0]=0
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  read data valid; responses return in order, at least 1 cycle after gnt
- bus_rdata_i  in  32  read data
- inst_o  out  32  instruction to decode
- inst_addr_o  out  32  address of inst_o
- inst_valid_o  out  1  inst_o is valid
- inst_ready_i  in  1  decode accepts inst_o

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - pc=BOOT_ADDR, FIFO empty, outstanding=0, discard=0, started=0.
  - Outputs: bus_req_o=0, bus_addr_o=BOOT_ADDR, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
  - started sets on the first clock edge after release, so bus_req_o stays low for exactly one cycle after reset release.
- Request issue (combinational): bus_req_o = started & ~hold_i & ~jump_flag_i & (fifo_count + outstanding < FIFO_DEPTH).
  - bus_addr_o = pc.
  - On req&gnt: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0) and outstanding += 1.
- Response:
  - On rvalid: outstanding -= 1.
  - If discard>0: discard -= 1 and the word is dropped.
  - Otherwise the word is pushed together with its address. A separate response-address register tracks the next expected address; it advances by 4 per accepted response and is loaded on redirect.
  - The credit rule prevents overflow; a push into a full FIFO is a design error and is flagged by an assertion.
- Output:
  - inst_valid_o = FIFO non-empty. inst_o/inst_addr_o come from the FIFO head, or NOP_INST/0 when empty.
  - Pop on valid&ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Zero-latency bypass is not provided: a word is visible the cycle after rvalid.
- Redirect (jump_flag_i=1, applied at the clock edge):
  - pc and response-address register <= {jump_addr_i[31:2],2'b00}.
  - FIFO cleared; any same-cycle push or pop is ignored.
  - discard <= outstanding - (rvalid & discard==0 ? 1 : 0) - (rvalid & discard>0 ? 1 : 0), i.e. every response not yet returned at the edge is dropped. A response arriving in the same cycle as jump is dropped.
  - bus_req_o is low during the jump cycle. The first new-target request may issue the next cycle.
  - Back-to-back jumps: the last one wins, and discard stays consistent.
- Hold:
  - Blocks new requests only.
  - Outstanding responses still land.
  - The FIFO still drains to decode.
- Counter widths: clog2(FIFO_DEPTH)+1 bits; no wrap under legal operation.
- Reset mid-transaction: all state clears immediately. Responses arriving after release with outstanding=0 are ignored, and an assertion fires in simulation.

Test Plan:
- Reset release, bus with gnt always high and rvalid 1 cycle later, ready=1:
  - bus_req_o low for 1 cycle, then addresses 0x0, 0x4, 0x8.
  - inst_valid_o first high 3 cycles after release.
  - inst_addr_o sequence 0x0, 0x4, 0x8 with the matching data.
- ready=0 with FIFO_DEPTH=2: after 2 words are buffered, bus_req_o stays low. Raising ready pops 0x0, then requests resume at 0x8 with no word lost or duplicated.
- Two requests outstanding (0x10, 0x14), then jump_flag_i with jump_addr_i=0x103:
  - Both returning words are dropped.
  - The next request address is 0x100.
  - First inst_addr_o after the jump is 0x100.
- jump_flag_i in the same cycle as rvalid for 0x20, with FIFO holding 0x1C:
  - FIFO empty next cycle.
  - Neither 0x1C nor 0x20 is ever presented.
- hold_i=1 for 5 cycles with 1 outstanding: no req during the hold, the outstanding word is still delivered, and requests resume the cycle hold falls.
- PC at 0xFFFF_FFFC: the next request address after it is 0x0000_0000. Separately, asserting rst_ni=0 mid-stream immediately forces inst_valid_o=0 and bus_req_o=0.
